// File: rtl/chip8_fb_draw.sv
// CHIP-8 display engine: CLS and DXYN sprite draw into a 64x32 one-bit framebuffer.
// Sprite bytes are fetched one row at a time and XORed in with wrap-around on both axes.
module chip8_fb_draw (
   input  logic          clk50,
   input  logic          reset,
   input  logic          cmd_clear,
   input  logic          cmd_draw,
   input  logic [7:0]    draw_x,
   input  logic [7:0]    draw_y,
   input  logic [3:0]    draw_n,
   input  logic [11:0]   draw_i,
   output logic          mem_rd_en,
   output logic [11:0]   mem_addr,
   input  logic [7:0]    mem_rd_data,
   output logic          busy,
   output logic          done,
   output logic          collision,
   output logic [2047:0] framebuffer
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_XOR   = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]  state_reg;
   logic [5:0]  x_reg;
   logic [4:0]  y_reg;
   logic [3:0]  n_reg;
   logic [3:0]  row_reg;
   logic [4:0]  pix_row;
   logic [10:0] pix_idx [8];
   logic [7:0]  pix_on;
   logic [7:0]  pix_hit;
   logic        unused_coord_bits;

   // Only the low coordinate bits matter: the screen wraps at 64 columns and 32 rows.
   assign unused_coord_bits = &{draw_x[7:6], draw_y[7:5]};

   assign pix_row = y_reg + {1'b0, row_reg};

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_pix
         logic [5:0] col;
         assign col         = x_reg + 6'(gi);
         assign pix_idx[gi] = {pix_row, col};
         assign pix_on[gi]  = mem_rd_data[7-gi];
         assign pix_hit[gi] = pix_on[gi] & framebuffer[pix_idx[gi]];
      end
   endgenerate

   assign mem_rd_en = (state_reg == ST_FETCH);
   assign busy      = (state_reg == ST_FETCH) || (state_reg == ST_XOR);
   assign done      = (state_reg == ST_DONE);

   always_ff @(posedge clk50 or posedge reset) begin
      if (reset) begin
         state_reg   <= ST_IDLE;
         x_reg       <= '0;
         y_reg       <= '0;
         n_reg       <= '0;
         row_reg     <= '0;
         mem_addr    <= '0;
         collision   <= 1'b0;
         framebuffer <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (cmd_clear) begin
                  framebuffer <= '0;
                  collision   <= 1'b0;
                  state_reg   <= ST_DONE;
               end else if (cmd_draw) begin
                  collision <= 1'b0;
                  if (draw_n != 4'd0) begin
                     x_reg     <= draw_x[5:0];
                     y_reg     <= draw_y[4:0];
                     n_reg     <= draw_n;
                     row_reg   <= '0;
                     mem_addr  <= draw_i;
                     state_reg <= ST_FETCH;
                  end else begin
                     state_reg <= ST_DONE;
                  end
               end
            end
            ST_FETCH: state_reg <= ST_XOR;
            ST_XOR: begin
               // The 8 target columns are distinct mod 64, so the writes never overlap.
               for (int k = 0; k < 8; k++)
                  framebuffer[pix_idx[k]] <= framebuffer[pix_idx[k]] ^ pix_on[k];
               if (|pix_hit)
                  collision <= 1'b1;
               if (row_reg == n_reg - 4'd1) begin
                  state_reg <= ST_DONE;
               end else begin
                  row_reg   <= row_reg + 4'd1;
                  mem_addr  <= mem_addr + 12'd1;
                  state_reg <= ST_FETCH;
               end
            end
            ST_DONE: state_reg <= ST_IDLE;
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_chip8_fb_draw.sv
// Bench for chip8_fb_draw: directed CHIP-8 draw scenarios plus random draws,
// all checked against a pixel-level model of CLS/DXYN.
module tb_chip8_fb_draw;

   logic          clk50 = 1'b0;
   logic          reset;
   logic          cmd_clear;
   logic          cmd_draw;
   logic [7:0]    draw_x;
   logic [7:0]    draw_y;
   logic [3:0]    draw_n;
   logic [11:0]   draw_i;
   logic          mem_rd_en;
   logic [11:0]   mem_addr;
   logic [7:0]    mem_rd_data;
   logic          busy;
   logic          done;
   logic          collision;
   logic [2047:0] framebuffer;

   logic [7:0]    mem [4096];
   logic [2047:0] model_fb;
   logic          model_coll;
   int            n_cmp;
   int            n_bad;

   chip8_fb_draw dut (
      .clk50       (clk50),
      .reset       (reset),
      .cmd_clear   (cmd_clear),
      .cmd_draw    (cmd_draw),
      .draw_x      (draw_x),
      .draw_y      (draw_y),
      .draw_n      (draw_n),
      .draw_i      (draw_i),
      .mem_rd_en   (mem_rd_en),
      .mem_addr    (mem_addr),
      .mem_rd_data (mem_rd_data),
      .busy        (busy),
      .done        (done),
      .collision   (collision),
      .framebuffer (framebuffer)
   );

   always #10 clk50 = ~clk50;

   // Sprite memory with one-cycle read latency.
   always @(posedge clk50)
      if (mem_rd_en)
         mem_rd_data <= mem[mem_addr];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_fb(input string tag);
      for (int r = 0; r < 32; r++)
         chk($sformatf("%s_fb_row%0d", tag, r), framebuffer[r*64 +: 64], model_fb[r*64 +: 64]);
   endtask

   task automatic model_draw(input logic [7:0] x, input logic [7:0] y,
                             input logic [3:0] n, input logic [11:0] i);
      logic [7:0] b;
      int idx;
      model_coll = 1'b0;
      for (int r = 0; r < int'(n); r++) begin
         b = mem[(int'(i) + r) % 4096];
         for (int k = 0; k < 8; k++) begin
            if (b[7-k]) begin
               idx = ((int'(y) + r) % 32) * 64 + (int'(x) + k) % 64;
               if (model_fb[idx])
                  model_coll = 1'b1;
               model_fb[idx] = ~model_fb[idx];
            end
         end
      end
   endtask

   // Issue one command and follow it to its done pulse, checking timing and results.
   task automatic do_cmd(input string tag, input bit clr, input bit drw,
                         input logic [7:0] x, input logic [7:0] y, input logic [3:0] n,
                         input logic [11:0] i, input bit poke, input bit now);
      int exp_n, done_at, busy_cnt, rd_cnt;
      if (!now)
         @(negedge clk50);
      cmd_clear = clr;
      cmd_draw  = drw;
      draw_x    = x;
      draw_y    = y;
      draw_n    = n;
      draw_i    = i;
      if (clr) begin
         model_fb   = '0;
         model_coll = 1'b0;
         exp_n      = 0;
      end else if (drw) begin
         model_draw(x, y, n, i);
         exp_n = int'(n);
      end else begin
         exp_n = 0;
      end
      @(posedge clk50);
      #1;
      cmd_clear = 1'b0;
      cmd_draw  = 1'b0;
      done_at   = 0;
      busy_cnt  = 0;
      rd_cnt    = 0;
      for (int c = 1; c <= 40 && done_at == 0; c++) begin
         @(negedge clk50);
         if (poke && c == 2) begin
            cmd_clear = 1'b1;
            cmd_draw  = 1'b1;
         end
         if (poke && c == 3) begin
            cmd_clear = 1'b0;
            cmd_draw  = 1'b0;
         end
         if (busy)
            busy_cnt++;
         if (mem_rd_en) begin
            chk({tag, "_mem_addr"}, 64'(mem_addr), 64'((int'(i) + rd_cnt) % 4096));
            rd_cnt++;
         end
         if (done)
            done_at = c;
      end
      cmd_clear = 1'b0;
      cmd_draw  = 1'b0;
      chk({tag, "_done_cycle"}, 64'(done_at), 64'(1 + 2 * exp_n));
      chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(2 * exp_n));
      chk({tag, "_rd_count"}, 64'(rd_cnt), 64'(exp_n));
      chk({tag, "_collision"}, 64'(collision), 64'(model_coll));
      check_fb(tag);
      @(negedge clk50);
      chk({tag, "_done_single"}, 64'(done), 64'd0);
      $display("%s: clr=%0d drw=%0d x=%0d y=%0d n=%0d i=%03h poke=%0d -> done@%0d busy=%0d coll=%0d",
               tag, clr, drw, x, y, n, i, poke, done_at, busy_cnt, collision);
   endtask

   initial begin
      n_cmp       = 0;
      n_bad       = 0;
      reset       = 1'b1;
      cmd_clear   = 1'b0;
      cmd_draw    = 1'b0;
      draw_x      = '0;
      draw_y      = '0;
      draw_n      = '0;
      draw_i      = '0;
      mem_rd_data = '0;
      model_fb    = '0;
      model_coll  = 1'b0;
      for (int a = 0; a < 4096; a++)
         mem[a] = 8'($urandom);
      mem[12'h050] = 8'hF0; mem[12'h051] = 8'h90; mem[12'h052] = 8'h90;
      mem[12'h053] = 8'h90; mem[12'h054] = 8'hF0;
      mem[12'h200] = 8'hFF; mem[12'h201] = 8'h81;
      mem[12'h300] = 8'h80;
      for (int a = 12'h100; a < 12'h104; a++)
         mem[a] = 8'hFF;

      repeat (3) @(negedge clk50);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_coll", 64'(collision), 64'd0);
      chk("rst_rd_en", 64'(mem_rd_en), 64'd0);
      chk("rst_addr", 64'(mem_addr), 64'd0);
      check_fb("rst");
      $display("reset: busy=%0d done=%0d coll=%0d", busy, done, collision);

      // First command goes in on the very first edge with reset low.
      reset = 1'b0;
      do_cmd("font0", 1'b0, 1'b1, 8'd0, 8'd0, 4'd5, 12'h050, 1'b0, 1'b1);
      chk("font0_row0_const", framebuffer[63:0], 64'h000000000000000F);
      chk("font0_row1_const", framebuffer[127:64], 64'h0000000000000009);
      do_cmd("font0_again", 1'b0, 1'b1, 8'd0, 8'd0, 4'd5, 12'h050, 1'b0, 1'b0);
      chk("font0_again_coll_const", 64'(collision), 64'd1);
      do_cmd("wrap", 1'b0, 1'b1, 8'd62, 8'd31, 4'd2, 12'h200, 1'b0, 1'b0);
      chk("wrap_row0_const", framebuffer[63:0], 64'h4000000000000020);
      do_cmd("cls", 1'b1, 1'b0, 8'd0, 8'd0, 4'd0, 12'h000, 1'b0, 1'b0);
      do_cmd("coord_mod", 1'b0, 1'b1, 8'h48, 8'h25, 4'd1, 12'h300, 1'b0, 1'b0);
      chk("coord_mod_bit328", 64'(framebuffer[328]), 64'd1);
      do_cmd("clr_wins", 1'b1, 1'b1, 8'd3, 8'd4, 4'd3, 12'h050, 1'b0, 1'b0);
      do_cmd("addr_wrap", 1'b0, 1'b1, 8'd10, 8'd20, 4'd5, 12'hFFE, 1'b1, 1'b0);

      for (int t = 0; t < 10; t++)
         do_cmd($sformatf("rand%0d", t), 1'b0, 1'b1, 8'($urandom), 8'($urandom),
                4'($urandom_range(0, 15)), 12'($urandom), 1'($urandom), 1'b0);

      // Reset in the XOR cycle of row 2 of a 4-row draw.
      @(negedge clk50);
      cmd_draw = 1'b1;
      draw_x   = 8'd20;
      draw_y   = 8'd10;
      draw_n   = 4'd4;
      draw_i   = 12'h100;
      @(posedge clk50);
      #1;
      cmd_draw = 1'b0;
      repeat (6) @(negedge clk50);
      chk("abort_busy_before", 64'(busy), 64'd1);
      reset = 1'b1;
      #1;
      model_fb   = '0;
      model_coll = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_coll", 64'(collision), 64'd0);
      chk("abort_rd_en", 64'(mem_rd_en), 64'd0);
      chk("abort_addr", 64'(mem_addr), 64'd0);
      check_fb("abort");
      for (int c = 0; c < 3; c++) begin
         @(negedge clk50);
         chk("abort_no_done", 64'(done), 64'd0);
      end
      $display("abort: busy=%0d done=%0d coll=%0d", busy, done, collision);
      reset = 1'b0;
      do_cmd("n0_after_rst", 1'b0, 1'b1, 8'd5, 8'd5, 4'd0, 12'h100, 1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
